// File: rtl/mem_store_buffer_pkg.sv
// Shared sizing for the store buffer: default address/data widths and FIFO depth.
package mem_store_buffer_pkg;
  localparam int unsigned SIZE_ADDR     = 16;
  localparam int unsigned SIZE_DATA     = 32;
  localparam int unsigned SIZE_SB_DEPTH = 4;
  localparam int unsigned HBIT_SB_PTR   = $clog2(SIZE_SB_DEPTH) - 1;
endpackage

// File: rtl/mem_store_buffer_match.sv
// Load-forwarding lookup: newest valid entry whose address matches the load wins.
module sb_match
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SIZE_SB_DEPTH,
  parameter int unsigned ADDR_W = SIZE_ADDR,
  parameter int unsigned DATA_W = SIZE_DATA,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_arr,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_arr,
  input  logic [PTR_W-1:0]             rd_ptr,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to newest from the head so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (valid[idx] && (addr_arr[idx] == ld_addr)) begin
        hit  = 1'b1;
        data = data_arr[idx];
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Store buffer on the write side of the unified mem port: queues MA stores,
// drains them when fetch leaves the port idle (or when forced), forwards to loads.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SIZE_SB_DEPTH,
  parameter int unsigned ADDR_W = SIZE_ADDR,
  parameter int unsigned DATA_W = SIZE_DATA
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst,
  input  logic                     iw_st_valid,
  input  logic [ADDR_W-1:0]        iw_st_addr,
  input  logic [DATA_W-1:0]        iw_st_data,
  output logic                     ow_st_ready,
  input  logic                     iw_ld_check,
  input  logic [ADDR_W-1:0]        iw_ld_addr,
  output logic                     ow_ld_hit,
  output logic [DATA_W-1:0]        ow_ld_data,
  input  logic                     iw_fetch_req,
  input  logic                     iw_drain,
  output logic                     ow_fetch_stall,
  output logic                     ow_mem_we,
  output logic [ADDR_W-1:0]        ow_mem_addr,
  output logic [DATA_W-1:0]        ow_mem_wdata,
  output logic                     ow_empty,
  output logic [$clog2(DEPTH):0]   ow_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             count;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid;
  logic                         full, empty, push, pop;
  logic                         m_hit;
  logic [DATA_W-1:0]            m_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = iw_st_valid && !full;
  assign pop   = ow_mem_we;

  assign ow_st_ready    = !full;
  assign ow_mem_we      = !empty && (!iw_fetch_req || full || iw_drain);
  assign ow_fetch_stall = iw_fetch_req && ow_mem_we;
  assign ow_mem_addr    = empty ? '0 : addr_q[rd_ptr];
  assign ow_mem_wdata   = empty ? '0 : data_q[rd_ptr];
  assign ow_empty       = empty;
  assign ow_count       = count;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines which slots are live.
  always_ff @(posedge iw_clk) begin
    if (push && !iw_rst) begin
      addr_q[wr_ptr] <= iw_st_addr;
      data_q[wr_ptr] <= iw_st_data;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
    end
  end

  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_match (
    .valid    (valid),
    .addr_arr (addr_q),
    .data_arr (data_q),
    .rd_ptr   (rd_ptr),
    .ld_addr  (iw_ld_addr),
    .hit      (m_hit),
    .data     (m_data)
  );

  assign ow_ld_hit  = iw_ld_check && m_hit;
  assign ow_ld_data = ow_ld_hit ? m_data : '0;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: directed scenarios plus random traffic against a queue model.
module tb_mem_store_buffer;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, st_valid, st_ready, ld_check, ld_hit, fetch_req, drain;
  logic        fetch_stall, mem_we, empty;
  logic [15:0] st_addr, ld_addr, mem_addr;
  logic [31:0] st_data, ld_data, mem_wdata;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  ent_t q[$];
  logic        e_ready, e_we, e_stall, e_hit, e_empty;
  logic [15:0] e_addr;
  logic [31:0] e_wdata, e_ld;
  logic [2:0]  e_count;

  always #5 clk = ~clk;

  mem_store_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(32)) dut (
    .iw_clk(clk), .iw_rst(rst),
    .iw_st_valid(st_valid), .iw_st_addr(st_addr), .iw_st_data(st_data), .ow_st_ready(st_ready),
    .iw_ld_check(ld_check), .iw_ld_addr(ld_addr), .ow_ld_hit(ld_hit), .ow_ld_data(ld_data),
    .iw_fetch_req(fetch_req), .iw_drain(drain), .ow_fetch_stall(fetch_stall),
    .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
    .ow_empty(empty), .ow_count(count)
  );

  // Apply inputs and derive the expected outputs from the queue model.
  task automatic drive(input logic sv, input logic [15:0] sa, input logic [31:0] sd,
                       input logic lc, input logic [15:0] la, input logic fr, input logic dr);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_check = lc; ld_addr = la; fetch_req = fr; drain = dr;
    e_count = 3'(q.size());
    e_empty = (q.size() == 0);
    e_ready = (q.size() < 4);
    e_we    = (q.size() > 0) && (!fr || q.size() == 4 || dr);
    e_stall = fr && e_we;
    e_addr  = (q.size() > 0) ? q[0].a : 16'h0;
    e_wdata = (q.size() > 0) ? q[0].d : 32'h0;
    e_hit = 1'b0;
    e_ld  = 32'h0;
    if (lc) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == la) begin
          e_hit = 1'b1;
          e_ld  = q[i].d;
          break;
        end
      end
    end
    #1;
  endtask

  task automatic tick();
    ent_t e;
    logic do_push;
    do_push = st_valid && e_ready;
    e.a = st_addr;
    e.d = st_data;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (e_we) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain_all();
    for (int n = 0; n < 16 && q.size() > 0; n++) begin
      drive(0, 16'h0, 32'h0, 0, 16'h0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 16'h1234, 32'hDEAD, 0, 16'h0, 0, 0);
    tick();
    drive(1, 16'h1234, 32'hDEAD, 1, 16'h1234, 0, 0);
    tick();
    drive(1, 16'h1234, 32'hDEAD, 1, 16'h1234, 0, 0);
    tests += 4;
    if (count !== 3'd0)   begin fails++; $display("FAIL reset_count: got %0d exp 0", count); end
    if (st_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b exp 1", st_ready); end
    if (mem_we !== 1'b0)  begin fails++; $display("FAIL reset_we: got %0b exp 0", mem_we); end
    if (ld_hit !== 1'b0)  begin fails++; $display("FAIL reset_hit: got %0b exp 0", ld_hit); end
    rst = 1'b0;
    drive(0, 16'h0, 32'h0, 0, 16'h0, 0, 0);
    tests += 2;
    if (empty !== 1'b1)   begin fails++; $display("FAIL reset_empty: got %0b exp 1", empty); end
    if (fetch_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b exp 0", fetch_stall); end
  endtask

  task automatic test_idle_drain();
    drive(1, 16'h0010, 32'hAA, 0, 16'h0, 0, 0);
    tests++;
    if (mem_we !== 1'b0) begin fails++; $display("FAIL idle_same_cycle_we: got %0b exp 0", mem_we); end
    tick();
    drive(0, 16'h0, 32'h0, 0, 16'h0, 0, 0);
    tests += 3;
    if (mem_we !== 1'b1)        begin fails++; $display("FAIL idle_we: got %0b exp 1", mem_we); end
    if (mem_addr !== 16'h0010)  begin fails++; $display("FAIL idle_addr: got %0h exp 10", mem_addr); end
    if (mem_wdata !== 32'hAA)   begin fails++; $display("FAIL idle_wdata: got %0h exp aa", mem_wdata); end
    tick();
    drive(0, 16'h0, 32'h0, 0, 16'h0, 0, 0);
    tests++;
    if (empty !== 1'b1) begin fails++; $display("FAIL idle_empty: got %0b exp 1", empty); end
  endtask

  task automatic test_fetch_priority();
    logic [15:0] order[4];
    for (int i = 0; i < 4; i++) begin
      order[i] = 16'($urandom_range(16'hFFFF));
      drive(1, order[i], $urandom, 0, 16'h0, 1, 0);
      tests++;
      if (mem_we !== 1'b0) begin fails++; $display("FAIL prio_early_we[%0d]: got %0b exp 0", i, mem_we); end
      tick();
    end
    drive(1, 16'h5555, 32'h5555, 0, 16'h0, 1, 0);
    tests += 5;
    if (count !== 3'd4)       begin fails++; $display("FAIL prio_count: got %0d exp 4", count); end
    if (st_ready !== 1'b0)    begin fails++; $display("FAIL prio_ready: got %0b exp 0", st_ready); end
    if (mem_we !== 1'b1)      begin fails++; $display("FAIL prio_we: got %0b exp 1", mem_we); end
    if (fetch_stall !== 1'b1) begin fails++; $display("FAIL prio_stall: got %0b exp 1", fetch_stall); end
    if (mem_addr !== order[0]) begin fails++; $display("FAIL prio_order[0]: got %0h exp %0h", mem_addr, order[0]); end
    tick();
    for (int i = 1; i < 4; i++) begin
      drive(0, 16'h0, 32'h0, 0, 16'h0, 0, 0);
      tests++;
      if (mem_we !== 1'b1 || mem_addr !== order[i]) begin
        fails++; $display("FAIL prio_order[%0d]: got we=%0b addr=%0h exp we=1 addr=%0h", i, mem_we, mem_addr, order[i]);
      end
      tick();
    end
    drive(0, 16'h0, 32'h0, 0, 16'h0, 0, 0);
    tests++;
    if (empty !== 1'b1) begin fails++; $display("FAIL prio_empty_after: got %0b exp 1", empty); end
  endtask

  task automatic test_forwarding();
    drive(1, 16'h0020, 32'd1, 0, 16'h0, 1, 0); tick();
    drive(1, 16'h0020, 32'd2, 0, 16'h0, 1, 0); tick();
    drive(0, 16'h0, 32'h0, 1, 16'h0020, 1, 0);
    tests += 2;
    if (ld_hit !== 1'b1)  begin fails++; $display("FAIL fwd_hit: got %0b exp 1", ld_hit); end
    if (ld_data !== 32'd2) begin fails++; $display("FAIL fwd_newest: got %0h exp 2", ld_data); end
    drive(0, 16'h0, 32'h0, 1, 16'h0021, 1, 0);
    tests += 2;
    if (ld_hit !== 1'b0)  begin fails++; $display("FAIL fwd_miss_hit: got %0b exp 0", ld_hit); end
    if (ld_data !== 32'd0) begin fails++; $display("FAIL fwd_miss_data: got %0h exp 0", ld_data); end
    drive(0, 16'h0, 32'h0, 0, 16'h0020, 1, 0);
    tests++;
    if (ld_hit !== 1'b0) begin fails++; $display("FAIL fwd_nocheck: got %0b exp 0", ld_hit); end
    drive(1, 16'h0030, 32'd3, 1, 16'h0030, 1, 0);
    tests++;
    if (ld_hit !== 1'b0) begin fails++; $display("FAIL fwd_same_cycle_push: got %0b exp 0", ld_hit); end
    tick();
    drive(0, 16'h0, 32'h0, 1, 16'h0030, 1, 0);
    tests++;
    if (ld_hit !== 1'b1 || ld_data !== 32'd3) begin
      fails++; $display("FAIL fwd_next_cycle: got hit=%0b data=%0h exp hit=1 data=3", ld_hit, ld_data);
    end
    // Head entry (0x20,1) is being written, newer (0x20,2) still pending behind it.
    drive(0, 16'h0, 32'h0, 1, 16'h0020, 0, 0);
    tests++;
    if (mem_we !== 1'b1 || ld_hit !== 1'b1 || ld_data !== 32'd2) begin
      fails++; $display("FAIL fwd_during_write: got we=%0b hit=%0b data=%0h exp we=1 hit=1 data=2", mem_we, ld_hit, ld_data);
    end
    drain_all();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'(16'h0100 + i), 32'(i), 0, 16'h0, 1, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'(16'h0200 + i), 32'(i + 100), 0, 16'h0, 0, 0);
      tests += 2;
      if (mem_we !== 1'b1 || mem_addr !== e_addr) begin
        fails++; $display("FAIL wrap_order[%0d]: got we=%0b addr=%0h exp we=1 addr=%0h", i, mem_we, mem_addr, e_addr);
      end
      if (count !== 3'd3) begin fails++; $display("FAIL wrap_count[%0d]: got %0d exp 3", i, count); end
      tick();
    end
    drain_all();
  endtask

  task automatic test_drain_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'(16'h0300 + i), 32'(i), 0, 16'h0, 1, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 16'h0, 32'h0, 0, 16'h0, 1, 1);
      tests++;
      if (mem_we !== 1'b1 || fetch_stall !== 1'b1 || mem_addr !== 16'(16'h0300 + i)) begin
        fails++; $display("FAIL drain_write[%0d]: got we=%0b stall=%0b addr=%0h exp we=1 stall=1 addr=%0h",
                          i, mem_we, fetch_stall, mem_addr, 16'(16'h0300 + i));
      end
      tick();
    end
    drive(0, 16'h0, 32'h0, 0, 16'h0, 1, 1);
    tests++;
    if (empty !== 1'b1 || mem_we !== 1'b0) begin
      fails++; $display("FAIL drain_done: got empty=%0b we=%0b exp empty=1 we=0", empty, mem_we);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'(16'h0400 + i), 32'(i), 0, 16'h0, 1, 0);
      tick();
    end
    drive(0, 16'h0, 32'h0, 0, 16'h0, 1, 1);
    tick();
    rst = 1'b1;
    drive(0, 16'h0, 32'h0, 0, 16'h0, 1, 1);
    tick();
    rst = 1'b0;
    drive(0, 16'h0, 32'h0, 1, 16'h0402, 1, 1);
    tests += 3;
    if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mid_we: got %0b exp 0", mem_we); end
    if (count !== 3'd0)  begin fails++; $display("FAIL rst_mid_count: got %0d exp 0", count); end
    if (ld_hit !== 1'b0) begin fails++; $display("FAIL rst_mid_hit: got %0b exp 0", ld_hit); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 3) != 0, 16'($urandom % 6), $urandom, $urandom % 2,
            16'($urandom % 6), ($urandom % 4) != 0, ($urandom % 8) == 0);
      tests++;
      if (st_ready !== e_ready || mem_we !== e_we || fetch_stall !== e_stall ||
          mem_addr !== e_addr || mem_wdata !== e_wdata || ld_hit !== e_hit ||
          ld_data !== e_ld || empty !== e_empty || count !== e_count) begin
        fails++;
        $display("FAIL rand[%0d]: got rdy=%0b we=%0b stl=%0b a=%0h d=%0h hit=%0b ld=%0h emp=%0b cnt=%0d exp rdy=%0b we=%0b stl=%0b a=%0h d=%0h hit=%0b ld=%0h emp=%0b cnt=%0d",
                 n, st_ready, mem_we, fetch_stall, mem_addr, mem_wdata, ld_hit, ld_data, empty, count,
                 e_ready, e_we, e_stall, e_addr, e_wdata, e_hit, e_ld, e_empty, e_count);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_check = 1'b0; ld_addr = '0; fetch_req = 1'b0; drain = 1'b0;
    test_reset();
    test_idle_drain();
    test_fetch_priority();
    test_forwarding();
    test_wrap();
    test_drain_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
